// File: rtl/display_mux_driver_if.sv
// Signal bundle between the dual-digit display multiplexer and its host logic.
// The slave side is the multiplexer; the master side supplies switches and enable.
interface display_mux_driver_if;
  logic       en;
  logic [3:0] s1;
  logic [3:0] s2;
  logic       current_hex;
  logic [3:0] s1_q;
  logic [3:0] s2_q;
  logic       an1_n;
  logic       an2_n;
  logic [4:0] sum;
  logic       frame_tick;

  modport master (
    output en,
    output s1,
    output s2,
    input  current_hex,
    input  s1_q,
    input  s2_q,
    input  an1_n,
    input  an2_n,
    input  sum,
    input  frame_tick
  );

  modport slave (
    input  en,
    input  s1,
    input  s2,
    output current_hex,
    output s1_q,
    output s2_q,
    output an1_n,
    output an2_n,
    output sum,
    output frame_tick
  );
endinterface

// File: rtl/display_mux_driver.sv
// Time-multiplexes two seven-segment digits with a blanking gap between them and
// snapshots the switch pair once per frame; every output is a register.
module display_mux_driver #(
  parameter int unsigned DIV_COUNT   = 24000,
  parameter int unsigned BLANK_COUNT = 480
) (
  input logic               clk,
  input logic               reset,
  display_mux_driver_if.slave bus
);

  localparam int unsigned CntMax =
    (DIV_COUNT > BLANK_COUNT) ? ((DIV_COUNT > 2) ? DIV_COUNT : 2)
                              : ((BLANK_COUNT > 2) ? BLANK_COUNT : 2);
  localparam int unsigned CntW = $clog2(CntMax);
  localparam logic [CntW-1:0] DivLast   = CntW'(DIV_COUNT - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_COUNT == 0) ? 0 : BLANK_COUNT - 1);
  localparam bit HasBlank = (BLANK_COUNT != 0);

  typedef enum logic [1:0] {
    StShow0  = 2'd0,
    StBlank0 = 2'd1,
    StShow1  = 2'd2,
    StBlank1 = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            frame_d;

  logic            hex_q, hex_d;
  logic            an1_n_q, an1_n_d;
  logic            an2_n_q, an2_n_d;
  logic [3:0]      snap1_q, snap2_q;
  logic [4:0]      sum_q;
  logic            tick_q;

  // Sequencing: state and count only advance on enabled cycles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (bus.en) begin
      unique case (state_q)
        StShow0: begin
          if (cnt_q == DivLast) begin
            cnt_d   = '0;
            state_d = HasBlank ? StBlank0 : StShow1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StBlank0: begin
          if (cnt_q == BlankLast) begin
            cnt_d   = '0;
            state_d = StShow1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StShow1: begin
          if (cnt_q == DivLast) begin
            cnt_d   = '0;
            state_d = HasBlank ? StBlank1 : StShow0;
            frame_d = !HasBlank;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StBlank1: begin
          if (cnt_q == BlankLast) begin
            cnt_d   = '0;
            state_d = StShow0;
            frame_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = StShow0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  // During blanking the select already points at the upcoming digit.
  always_comb begin
    an1_n_d = 1'b1;
    an2_n_d = 1'b1;
    hex_d   = hex_q;
    if (bus.en) begin
      unique case (state_d)
        StShow0: begin
          an1_n_d = 1'b0;
          hex_d   = 1'b0;
        end
        StBlank0: hex_d = 1'b1;
        StShow1: begin
          an2_n_d = 1'b0;
          hex_d   = 1'b1;
        end
        StBlank1: hex_d = 1'b0;
        default:  hex_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StShow0;
      cnt_q   <= '0;
      hex_q   <= 1'b0;
      an1_n_q <= 1'b0;
      an2_n_q <= 1'b1;
      snap1_q <= '0;
      snap2_q <= '0;
      sum_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hex_q   <= hex_d;
      an1_n_q <= an1_n_d;
      an2_n_q <= an2_n_d;
      tick_q  <= frame_d;
      if (frame_d) begin
        snap1_q <= bus.s1;
        snap2_q <= bus.s2;
        sum_q   <= {1'b0, bus.s1} + {1'b0, bus.s2};
      end
    end
  end

  assign bus.current_hex = hex_q;
  assign bus.an1_n       = an1_n_q;
  assign bus.an2_n       = an2_n_q;
  assign bus.s1_q        = snap1_q;
  assign bus.s2_q        = snap2_q;
  assign bus.sum         = sum_q;
  assign bus.frame_tick  = tick_q;

endmodule

// File: tb/tb_display_mux_driver.sv
// Directed bench for display_mux_driver: one DUT with blanking (4/2) and one without (1/0).
module tb_display_mux_driver;

  logic clk = 1'b0;
  logic reset;
  logic reset2;
  int   checks = 0;
  int   errors = 0;

  display_mux_driver_if bus ();
  display_mux_driver_if bus2 ();

  display_mux_driver #(.DIV_COUNT(4), .BLANK_COUNT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  display_mux_driver #(.DIV_COUNT(1), .BLANK_COUNT(0)) dut_nb (
    .clk   (clk),
    .reset (reset2),
    .bus   (bus2.slave)
  );

  always #5 clk = ~clk;

  // Expected {an1_n, an2_n, current_hex} at cycle k of an uninterrupted 4/2 sequence.
  function automatic logic [2:0] exp_drive(input int k);
    int pos;
    pos = k % 12;
    exp_drive = {!(pos < 4), !(pos >= 6 && pos < 10), (pos >= 4 && pos < 10)};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.an1_n, bus.an2_n, bus.current_hex} !== 3'b010) begin
      errors++;
      $display("FAIL reset_drive: got %b expected 010", {bus.an1_n, bus.an2_n, bus.current_hex});
    end
    @(negedge clk);
    checks++;
    if ({bus.s1_q, bus.s2_q, bus.sum, bus.frame_tick} !== 14'd0) begin
      errors++;
      $display("FAIL reset_data: got %h/%h/%h/%b expected 0/0/0/0",
               bus.s1_q, bus.s2_q, bus.sum, bus.frame_tick);
    end
  endtask

  task automatic test_sequence();
    logic [12:0] exp_snap;
    bus.en = 1'b1; bus.s1 = 4'd4; bus.s2 = 4'd5;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if ({bus.an1_n, bus.an2_n, bus.current_hex} !== exp_drive(k)) begin
        errors++;
        $display("FAIL seq_drive cycle %0d: got %b expected %b", k,
                 {bus.an1_n, bus.an2_n, bus.current_hex}, exp_drive(k));
      end
      checks++;
      if (bus.frame_tick !== (k == 12)) begin
        errors++;
        $display("FAIL seq_tick cycle %0d: got %b expected %b", k, bus.frame_tick, (k == 12));
      end
      exp_snap = (k >= 12) ? {4'd4, 4'd5, 5'd9} : 13'd0;
      checks++;
      if ({bus.s1_q, bus.s2_q, bus.sum} !== exp_snap) begin
        errors++;
        $display("FAIL seq_snap cycle %0d: got %h expected %h", k,
                 {bus.s1_q, bus.s2_q, bus.sum}, exp_snap);
      end
      if (k < 12) @(negedge clk);
    end
  endtask

  task automatic test_midframe_change();
    logic [12:0] exp_snap;
    bus.en = 1'b1; bus.s1 = 4'd8; bus.s2 = 4'd13;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 24; k++) begin
      if (k < 12)       exp_snap = 13'd0;
      else if (k < 24)  exp_snap = {4'd1, 4'd1, 5'd2};
      else              exp_snap = {4'd15, 4'd15, 5'd30};
      checks++;
      if ({bus.s1_q, bus.s2_q, bus.sum} !== exp_snap) begin
        errors++;
        $display("FAIL mid_snap cycle %0d: got %h expected %h", k,
                 {bus.s1_q, bus.s2_q, bus.sum}, exp_snap);
      end
      checks++;
      if (bus.frame_tick !== (k == 12 || k == 24)) begin
        errors++;
        $display("FAIL mid_tick cycle %0d: got %b expected %b", k, bus.frame_tick,
                 (k == 12 || k == 24));
      end
      if (k == 7) begin
        bus.s1 = 4'd1; bus.s2 = 4'd1;
      end
      if (k == 13) begin
        bus.s1 = 4'd15; bus.s2 = 4'd15;
      end
      if (k < 24) @(negedge clk);
    end
  endtask

  task automatic test_enable_freeze();
    logic [2:0] exp;
    bus.en = 1'b1; bus.s1 = 4'd2; bus.s2 = 4'd7;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 17; k++) begin
      if (k <= 1)      exp = exp_drive(k);
      else if (k <= 6) exp = 3'b110;
      else             exp = exp_drive(k - 5);
      checks++;
      if ({bus.an1_n, bus.an2_n, bus.current_hex} !== exp) begin
        errors++;
        $display("FAIL en_drive cycle %0d: got %b expected %b", k,
                 {bus.an1_n, bus.an2_n, bus.current_hex}, exp);
      end
      checks++;
      if (bus.frame_tick !== (k == 17)) begin
        errors++;
        $display("FAIL en_tick cycle %0d: got %b expected %b", k, bus.frame_tick, (k == 17));
      end
      if (k == 1) bus.en = 1'b0;
      if (k == 6) bus.en = 1'b1;
      if (k < 17) @(negedge clk);
    end
    checks++;
    if ({bus.s1_q, bus.s2_q, bus.sum} !== {4'd2, 4'd7, 5'd9}) begin
      errors++;
      $display("FAIL en_snap: got %h expected %h", {bus.s1_q, bus.s2_q, bus.sum},
               {4'd2, 4'd7, 5'd9});
    end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] exp_snap;
    bus.en = 1'b1; bus.s1 = 4'd6; bus.s2 = 4'd3;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 1; k <= 19; k++) @(negedge clk);
    checks++;
    if ({bus.an1_n, bus.an2_n, bus.current_hex, bus.s1_q, bus.s2_q, bus.sum}
        !== {3'b101, 4'd6, 4'd3, 5'd9}) begin
      errors++;
      $display("FAIL rst_pre: got %b/%h expected 101/639",
               {bus.an1_n, bus.an2_n, bus.current_hex}, {bus.s1_q, bus.s2_q, bus.sum});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.an1_n, bus.an2_n, bus.current_hex, bus.s1_q, bus.s2_q, bus.sum, bus.frame_tick}
        !== {3'b010, 14'd0}) begin
      errors++;
      $display("FAIL rst_async: got %b/%h/%b expected 010/000/0",
               {bus.an1_n, bus.an2_n, bus.current_hex}, {bus.s1_q, bus.s2_q, bus.sum},
               bus.frame_tick);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int k = 0; k <= 12; k++) begin
      checks++;
      if ({bus.an1_n, bus.an2_n, bus.current_hex} !== exp_drive(k)) begin
        errors++;
        $display("FAIL rst_restart cycle %0d: got %b expected %b", k,
                 {bus.an1_n, bus.an2_n, bus.current_hex}, exp_drive(k));
      end
      exp_snap = (k >= 12) ? {4'd6, 4'd3, 5'd9} : 13'd0;
      checks++;
      if ({bus.s1_q, bus.s2_q, bus.sum} !== exp_snap) begin
        errors++;
        $display("FAIL rst_snap cycle %0d: got %h expected %h", k,
                 {bus.s1_q, bus.s2_q, bus.sum}, exp_snap);
      end
      if (k < 12) @(negedge clk);
    end
  endtask

  task automatic test_no_blank();
    logic [2:0] exp;
    bus2.en = 1'b1; bus2.s1 = 4'd2; bus2.s2 = 4'd3;
    @(negedge clk);
    reset2 = 1'b0;
    #1;
    for (int k = 0; k <= 8; k++) begin
      exp = {(k % 2 == 1), (k % 2 == 0), (k % 2 == 1)};
      checks++;
      if ({bus2.an1_n, bus2.an2_n, bus2.current_hex} !== exp) begin
        errors++;
        $display("FAIL nb_drive cycle %0d: got %b expected %b", k,
                 {bus2.an1_n, bus2.an2_n, bus2.current_hex}, exp);
      end
      checks++;
      if (bus2.frame_tick !== (k >= 2 && k % 2 == 0)) begin
        errors++;
        $display("FAIL nb_tick cycle %0d: got %b expected %b", k, bus2.frame_tick,
                 (k >= 2 && k % 2 == 0));
      end
      if (k == 2) begin
        checks++;
        if ({bus2.s1_q, bus2.s2_q, bus2.sum} !== {4'd2, 4'd3, 5'd5}) begin
          errors++;
          $display("FAIL nb_snap: got %h expected %h", {bus2.s1_q, bus2.s2_q, bus2.sum},
                   {4'd2, 4'd3, 5'd5});
        end
      end
      if (k < 8) @(negedge clk);
    end
  endtask

  initial begin
    reset  = 1'b1;
    reset2 = 1'b1;
    bus.en = 1'b1;  bus.s1 = 4'd0;  bus.s2 = 4'd0;
    bus2.en = 1'b1; bus2.s1 = 4'd0; bus2.s2 = 4'd0;
    test_reset();
    test_sequence();
    test_midframe_change();
    test_enable_freeze();
    test_reset_midframe();
    test_no_blank();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
